// File: rtl/xm23_pkg.sv
// xm23_pkg
// Shared types and constants for the XM23 decimal-add writeback stage.
//   psw_t          : processor status word {v, n, z, c}
//   stage_state_t  : occupancy of the single-entry writeback register
//   WORD_W/BYTE_W  : XM23 word and byte widths
//   BCD_MAX_DIGIT  : largest legal packed-BCD nibble
package xm23_pkg;

    localparam int          WORD_W        = 16;
    localparam int          BYTE_W        = 8;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } psw_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/bcd_flag_calc.sv
// bcd_flag_calc
// Combinational flag derivation for a packed-BCD add result.
//   i_byte    : 1 = operate on the low byte only, 0 = full word
//   i_a, i_b  : source operands as presented to the adder
//   i_cin     : carry-in presented to the adder
//   i_sum     : adder result
//   o_c/o_z/o_n : decimal carry-out, zero, negative over the active width
//   o_bcd_err : some active-width nibble of a or b exceeds 9
//   o_data    : writeback value (byte mode keeps the old high byte of b)
module bcd_flag_calc
    import xm23_pkg::*;
#(
    parameter int DW = WORD_W
) (
    input  logic          i_byte,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_cin,
    input  logic [DW-1:0] i_sum,
    output logic          o_c,
    output logic          o_z,
    output logic          o_n,
    output logic          o_bcd_err,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_s;

    // Byte mode zero-extends the low byte so one unsigned compare covers both widths.
    assign w_a = i_byte ? {{(DW-BYTE_W){1'b0}}, i_a[BYTE_W-1:0]}   : i_a;
    assign w_b = i_byte ? {{(DW-BYTE_W){1'b0}}, i_b[BYTE_W-1:0]}   : i_b;
    assign w_s = i_byte ? {{(DW-BYTE_W){1'b0}}, i_sum[BYTE_W-1:0]} : i_sum;

    // Packed-BCD ordering equals unsigned nibble ordering, so a result that
    // wrapped below a (or landed exactly on a despite a nonzero addend) carried.
    assign o_c = (w_s < w_a) || ((w_s == w_a) && ((w_b != '0) || i_cin));
    assign o_z = (w_s == '0);
    assign o_n = i_byte ? i_sum[BYTE_W-1] : i_sum[DW-1];

    assign o_data = i_byte ? {i_b[DW-1:BYTE_W], i_sum[BYTE_W-1:0]} : i_sum;

    always_comb begin
        o_bcd_err = 1'b0;
        for (int i = 0; i < DW/4; i++) begin
            if (!i_byte || (i < BYTE_W/4)) begin
                if ((i_a[i*4 +: 4] > BCD_MAX_DIGIT) || (i_b[i*4 +: 4] > BCD_MAX_DIGIT)) begin
                    o_bcd_err = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dadd_flag_wb_stage.sv
// dadd_flag_wb_stage
// Single-entry register stage after the XM23 packed-BCD adder. Derives the
// decimal carry, Z/N flags and an invalid-BCD indication, and presents them
// with the writeback data to the register file and PSW update.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake
//   in_byte, in_dst, in_a, in_b, in_cin, in_sum, in_psw : operation fields
//   flush                : squash the held and the incoming operation
//   out_valid/out_ready  : downstream handshake; out_we mirrors out_valid
//   out_dst, out_data, out_psw, out_bcd_err : registered results
//   err_sticky           : set by any accepted op with a BCD error, cleared by rst
//   dbg_state            : stage occupancy (0 = EMPTY, 1 = FULL)
//
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready is
// combinational (!out_valid || out_ready), so a full stage being drained can load a
// new op on the same edge. While out_valid && !out_ready every out_* holds.
module dadd_flag_wb_stage
    import xm23_pkg::*;
#(
    parameter int DW = WORD_W,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_byte,
    input  logic [RW-1:0] in_dst,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_cin,
    input  logic [DW-1:0] in_sum,
    input  logic [3:0]    in_psw,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_we,
    output logic [RW-1:0] out_dst,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_psw,
    output logic          out_bcd_err,
    output logic          err_sticky,
    output logic          dbg_state
);

    stage_state_t  r_state;
    stage_state_t  w_state_next;
    logic          w_full;
    logic          w_in_ready;
    logic          w_load;
    logic          w_c;
    logic          w_z;
    logic          w_n;
    logic          w_bcd_err;
    logic [DW-1:0] w_data;
    logic [RW-1:0] r_dst;
    logic [DW-1:0] r_data;
    psw_t          r_psw;
    logic          r_bcd_err;
    logic          r_err_sticky;
    logic          w_unused;

    // Only V is forwarded from the incoming PSW; N/Z/C are recomputed.
    assign w_unused = ^in_psw[2:0];

    bcd_flag_calc #(.DW(DW)) u_flags (
        .i_byte    (in_byte),
        .i_a       (in_a),
        .i_b       (in_b),
        .i_cin     (in_cin),
        .i_sum     (in_sum),
        .o_c       (w_c),
        .o_z       (w_z),
        .o_n       (w_n),
        .o_bcd_err (w_bcd_err),
        .o_data    (w_data)
    );

    // Flush wins over a simultaneous accept: the incoming op is dropped.
    assign w_load = in_valid && w_in_ready && !flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) w_state_next = ST_FULL;
            end
            ST_FULL: begin
                if (flush)          w_state_next = ST_EMPTY;
                else if (out_ready) w_state_next = in_valid ? ST_FULL : ST_EMPTY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        w_full     = (r_state == ST_FULL);
        w_in_ready = !w_full || out_ready;
    end

    // Result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dst     <= '0;
            r_data    <= '0;
            r_psw     <= '0;
            r_bcd_err <= 1'b0;
        end else if (w_load) begin
            r_dst     <= in_dst;
            r_data    <= w_data;
            r_psw     <= '{v: in_psw[3], n: w_n, z: w_z, c: w_c};
            r_bcd_err <= w_bcd_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_load && w_bcd_err) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_full;
    assign out_we      = w_full;
    assign out_dst     = r_dst;
    assign out_data    = r_data;
    assign out_psw     = r_psw;
    assign out_bcd_err = r_bcd_err;
    assign err_sticky  = r_err_sticky;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_dadd_flag_wb_stage.sv
module tb_dadd_flag_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_byte;
  logic [2:0]  in_dst;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic [15:0] in_sum;
  logic [3:0]  in_psw;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_we;
  logic [2:0]  out_dst;
  logic [15:0] out_data;
  logic [3:0]  out_psw;
  logic        out_bcd_err;
  logic        err_sticky;
  logic        dbg_state;

  int checks;
  int failures;

  dadd_flag_wb_stage #(.DW(16), .RW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .in_dst      (in_dst),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .in_sum      (in_sum),
    .in_psw      (in_psw),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_we      (out_we),
    .out_dst     (out_dst),
    .out_data    (out_data),
    .out_psw     (out_psw),
    .out_bcd_err (out_bcd_err),
    .err_sticky  (err_sticky),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic byte_m, input logic [2:0] dst,
                       input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] sum, input logic [3:0] psw);
    in_valid = v;
    in_byte  = byte_m;
    in_dst   = dst;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sum   = sum;
    in_psw   = psw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 4'h0);
    flush = 1'b0;
    out_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_we, out_dst, out_data, out_psw, out_bcd_err, err_sticky} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b we=%b dst=%h data=%h psw=%h err=%b sticky=%b required all zero",
               out_valid, out_we, out_dst, out_data, out_psw, out_bcd_err, err_sticky);
    end
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got in_ready=%b state=%b required 1/0", in_ready, dbg_state);
    end
  endtask

  // Present one op with out_ready=1, then check the registered result one cycle later
  // and that the stage drains on the cycle after that.
  task automatic one_op(input string name, input logic byte_m, input logic [2:0] dst,
                        input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] sum, input logic [3:0] psw_in,
                        input logic [15:0] exp_data, input logic [3:0] exp_psw,
                        input logic exp_err);
    out_ready = 1'b1;
    drive(1'b1, byte_m, dst, a, b, cin, sum, psw_in);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 4'h0);
    #1;
    checks++;
    if ({out_valid, out_we, dbg_state, out_dst, out_data, out_psw, out_bcd_err} !==
        {1'b1, 1'b1, 1'b1, dst, exp_data, exp_psw, exp_err}) begin
      failures++;
      $display("FAIL %s: got v=%b we=%b st=%b dst=%h data=%h psw=%b err=%b required v=1 we=1 st=1 dst=%h data=%h psw=%b err=%b",
               name, out_valid, out_we, dbg_state, out_dst, out_data, out_psw, out_bcd_err,
               dst, exp_data, exp_psw, exp_err);
    end
    next_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got out_valid=%b required 0", name, out_valid);
    end
  endtask

  task automatic test_word();
    // 1234 + 5678 = 6912, V passed through from in_psw
    one_op("word_basic", 1'b0, 3'd1, 16'h1234, 16'h5678, 1'b0, 16'h6912, 4'b1000,
           16'h6912, 4'b1000, 1'b0);
    // 9999 + 0001 wraps to 0000: carry and zero
    one_op("word_wrap", 1'b0, 3'd2, 16'h9999, 16'h0001, 1'b0, 16'h0000, 4'b0000,
           16'h0000, 4'b0011, 1'b0);
    // 1234 + 9999 + 1 = 1234 with carry (equal case)
    one_op("word_equal", 1'b0, 3'd3, 16'h1234, 16'h9999, 1'b1, 16'h1234, 4'b0000,
           16'h1234, 4'b0001, 1'b0);
    // 1234 + 0000 + 0 = 1234: equal but nothing added, no carry
    one_op("word_equal_nocarry", 1'b0, 3'd4, 16'h1234, 16'h0000, 1'b0, 16'h1234, 4'b0000,
           16'h1234, 4'b0000, 1'b0);
  endtask

  task automatic test_byte();
    // 55 + 45 + 1 = 101: low byte 01 with carry, high byte of b kept
    one_op("byte_carry", 1'b1, 3'd5, 16'h0055, 16'hAB45, 1'b1, 16'h7701, 4'b0000,
           16'hAB01, 4'b0001, 1'b0);
    // 45 + 50 = 95: N from bit 7, old high byte 12 kept
    one_op("byte_neg", 1'b1, 3'd6, 16'h9945, 16'h1250, 1'b0, 16'h3395, 4'b0000,
           16'h1295, 4'b0100, 1'b0);
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear: got err_sticky=%b required 0", err_sticky);
    end
  endtask

  task automatic test_neg_err();
    one_op("word_neg", 1'b0, 3'd7, 16'h8000, 16'h0001, 1'b0, 16'h8001, 4'b0000,
           16'h8001, 4'b0100, 1'b0);
    // A0 is not BCD: error flagged, flags still computed
    one_op("word_bcd_err", 1'b0, 3'd1, 16'h00A0, 16'h0001, 1'b0, 16'h00A1, 4'b0000,
           16'h00A1, 4'b0000, 1'b1);
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set: got err_sticky=%b required 1", err_sticky);
    end
    // Clean op afterwards: per-op error clears, sticky stays
    one_op("after_err", 1'b0, 3'd2, 16'h0011, 16'h0022, 1'b0, 16'h0033, 4'b0000,
           16'h0033, 4'b0000, 1'b0);
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_hold: got err_sticky=%b required 1", err_sticky);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'd3, 16'h1234, 16'h5678, 1'b0, 16'h6912, 4'b0000);
    next_cycle();
    // op2 presented while op1 is stalled
    drive(1'b1, 1'b1, 3'd5, 16'h0055, 16'hAB45, 1'b1, 16'h7701, 4'b0000);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, out_dst, out_data, out_psw} !== {1'b0, 1'b1, 3'd3, 16'h6912, 4'b0000}) begin
        failures++;
        $display("FAIL hold_%0d: got rdy=%b v=%b dst=%h data=%h psw=%b required rdy=0 v=1 dst=3 data=6912 psw=0000",
                 i, in_ready, out_valid, out_dst, out_data, out_psw);
      end
      if (i < 2) next_cycle();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_ready: got in_ready=%b required 1", in_ready);
    end
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 4'h0);
    #1;
    checks++;
    if ({out_valid, out_dst, out_data, out_psw} !== {1'b1, 3'd5, 16'hAB01, 4'b0001}) begin
      failures++;
      $display("FAIL replace: got v=%b dst=%h data=%h psw=%b required v=1 dst=5 data=ab01 psw=0001",
               out_valid, out_dst, out_data, out_psw);
    end
    next_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL replace_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_t [3];
    logic [15:0] b_t [3];
    logic [15:0] s_t [3];
    logic [3:0]  p_t [3];
    a_t = '{16'h0001, 16'h4999, 16'h9000};
    b_t = '{16'h0002, 16'h0001, 16'h1000};
    s_t = '{16'h0003, 16'h5000, 16'h0000};
    p_t = '{4'b0000,  4'b0000,  4'b0011};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'(i), a_t[i], b_t[i], 1'b0, s_t[i], 4'b0000);
      next_cycle();
      #1;
      checks++;
      if ({in_ready, out_valid, out_dst, out_data, out_psw} !== {1'b1, 1'b1, 3'(i), s_t[i], p_t[i]}) begin
        failures++;
        $display("FAIL stream_%0d: got rdy=%b v=%b dst=%h data=%h psw=%b required rdy=1 v=1 dst=%0d data=%h psw=%b",
                 i, in_ready, out_valid, out_dst, out_data, out_psw, i, s_t[i], p_t[i]);
      end
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'd4, 16'h0010, 16'h0020, 1'b0, 16'h0030, 4'b0000);
    next_cycle();
    drive(1'b1, 1'b0, 3'd6, 16'h0040, 16'h0050, 1'b0, 16'h0090, 4'b0000);
    flush = 1'b1;
    out_ready = 1'b1;
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 4'h0);
    #1;
    checks++;
    if ({out_valid, out_we, dbg_state} !== 3'b000) begin
      failures++;
      $display("FAIL flush_full: got v=%b we=%b st=%b required 0/0/0", out_valid, out_we, dbg_state);
    end
    next_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_lost: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    // error op so sticky is certainly set before the reset
    drive(1'b1, 1'b0, 3'd7, 16'h00B0, 16'h0001, 1'b0, 16'h00B1, 4'b1000);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 4'h0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_we, out_dst, out_data, out_psw, out_bcd_err, err_sticky} !== 27'd0) begin
      failures++;
      $display("FAIL rst_hold: got v=%b we=%b dst=%h data=%h psw=%h err=%b sticky=%b required all zero",
               out_valid, out_we, out_dst, out_data, out_psw, out_bcd_err, err_sticky);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready: got in_ready=%b required 1", in_ready);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_word();
    test_byte();
    test_neg_err();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
